// File: rtl/wr_rd_seq_pkg.sv
// Shared types and constants for the write/read sequencer.
// State encoding, counter widths, parameter limits and the delay-counter preload helper.
package wr_rd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DLY,
        WR,
        GAP,
        RD,
        DONE,
        ERR
    } seq_state_t;

    localparam int DLY_W   = 4;
    localparam int TMO_W   = 8;
    localparam int HIT_W   = 8;
    localparam int DLY_MIN = 1;
    localparam int DLY_MAX = 15;
    localparam int TMO_MIN = 2;
    localparam int TMO_MAX = 255;

    // One cycle is spent entering the wait state and one registering the request,
    // so the counter only has to cover the remaining d-2 cycles.
    function automatic logic [DLY_W-1:0] cnt_preload(input int d);
        return (d >= 2) ? DLY_W'(d - 2) : '0;
    endfunction

endpackage

// File: rtl/seq_dly_cnt.sv
// Loadable down-counter that stops at zero; expired is high while the count is zero.
module seq_dly_cnt
    import wr_rd_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DLY_W-1:0] load_val,
    output logic             expired
);

    logic [DLY_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - DLY_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/wr_rd_sequencer.sv
// Start-triggered write-then-read request sequencer with ack timeouts and synchronous abort.
// Optional handshake hit counters are built when SEQ_HIT_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a start rising edge
// DLY   | start-to-write delay running
// WR    | wr held, waiting for wr_ack (timeout armed)
// GAP   | write-to-read gap running
// RD    | rd held, waiting for rd_ack (timeout armed)
// DONE  | done pulse, back to IDLE
// ERR   | err pulse after ack timeout, back to IDLE
module wr_rd_sequencer
    import wr_rd_seq_pkg::*;
#(
    parameter int START_DLY = 2,
    parameter int WR_RD_GAP = 2,
    parameter int TMO       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clr,
    input  logic wr_ack,
    input  logic rd_ack,
    output logic wr,
    output logic rd,
    output logic busy,
    output logic done,
    output logic err
`ifdef SEQ_HIT_CNT_EN
    ,
    output logic [HIT_W-1:0] hit_wr,
    output logic [HIT_W-1:0] hit_rd
`endif
);

    localparam logic [DLY_W-1:0] DLY_LD = cnt_preload(START_DLY);
    localparam logic [DLY_W-1:0] GAP_LD = cnt_preload(WR_RD_GAP);
    localparam logic [TMO_W-1:0] TMO_LD = TMO_W'(TMO - 1);

    seq_state_t       state;
    logic             start_q;
    logic             armed;
    logic             rise;
    logic [TMO_W-1:0] tmo_cnt;
    logic             dly_exp;
    logic             gap_exp;

    // armed blocks a start held high through reset release from looking like a rise
    assign rise = start && !start_q && armed;

    seq_dly_cnt u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == IDLE) && rise && !clr),
        .en       (state == DLY),
        .load_val (DLY_LD),
        .expired  (dly_exp)
    );

    seq_dly_cnt u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == WR) && wr_ack && !clr),
        .en       (state == GAP),
        .load_val (GAP_LD),
        .expired  (gap_exp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr      <= 1'b0;
            rd      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            tmo_cnt <= '0;
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= start;
            armed   <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            if (clr) begin
                state <= IDLE;
                wr    <= 1'b0;
                rd    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        busy <= 1'b1;
                        if (START_DLY <= 1) begin
                            state   <= WR;
                            wr      <= 1'b1;
                            tmo_cnt <= TMO_LD;
                        end else begin
                            state <= DLY;
                        end
                    end
                    DLY: if (dly_exp) begin
                        state   <= WR;
                        wr      <= 1'b1;
                        tmo_cnt <= TMO_LD;
                    end
                    WR: if (wr_ack) begin
                        wr <= 1'b0;
                        if (WR_RD_GAP <= 1) begin
                            state   <= RD;
                            rd      <= 1'b1;
                            tmo_cnt <= TMO_LD;
                        end else begin
                            state <= GAP;
                        end
                    end else if (tmo_cnt == '0) begin
                        state <= ERR;
                        wr    <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                    GAP: if (gap_exp) begin
                        state   <= RD;
                        rd      <= 1'b1;
                        tmo_cnt <= TMO_LD;
                    end
                    RD: if (rd_ack) begin
                        state <= DONE;
                        rd    <= 1'b0;
                        done  <= 1'b1;
                    end else if (tmo_cnt == '0) begin
                        state <= ERR;
                        rd    <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                    DONE, ERR: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        wr    <= 1'b0;
                        rd    <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_HIT_CNT_EN
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    // clr wins over a same-cycle ack, so an aborted handshake is not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_wr <= '0;
            hit_rd <= '0;
        end else begin
            if ((state == WR) && wr_ack && !clr && (hit_wr != HIT_MAX)) begin
                hit_wr <= hit_wr + HIT_W'(1);
            end
            if ((state == RD) && rd_ack && !clr && (hit_rd != HIT_MAX)) begin
                hit_rd <= hit_rd + HIT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/wr_rd_sequencer.md
WR_RD_SEQUENCER -- requirements
Module: wr_rd_sequencer

Interface
REQ-001 SHALL have parameter START_DLY, default 2: cycles from detected start rising edge to first wr assertion (legal range 1..15).
REQ-002 SHALL have parameter WR_RD_GAP, default 2: cycles from wr handshake to first rd assertion (legal range 1..15).
REQ-003 SHALL have parameter TMO, default 16: maximum cycles wr or rd waits for its ack (legal range 2..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  trigger level; only its rising edge is acted upon.
REQ-007 SHALL have port clr  input  1  synchronous abort.
REQ-008 SHALL have port wr_ack  input  1  downstream write accept.
REQ-009 SHALL have port rd_ack  input  1  downstream read accept.
REQ-010 SHALL have port wr  output  1  write request, held until accepted.
REQ-011 SHALL have port rd  output  1  read request, held until accepted.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-014 SHALL have port err  output  1  one-cycle pulse on ack timeout.

Function
REQ-015 SHALL register start and detect a rising edge as start=1 with the previous sample 0, giving the equivalent of $rose(start).
REQ-016 SHALL implement the states IDLE, DLY, WR, GAP, RD, DONE and ERR.
REQ-017 SHALL transition: IDLE->DLY on rise; DLY->WR when the count expires; WR->GAP on wr&&wr_ack; GAP->RD when the count expires; RD->DONE on rd&&rd_ack; DONE->IDLE; ERR->IDLE.
REQ-018 SHALL, when the rise is sampled at edge N, assert wr such that it is first sampled high at edge N+START_DLY.
REQ-019 SHALL, when wr&&wr_ack is sampled at edge M, deassert wr at M and first assert rd so that it is sampled high at M+WR_RD_GAP.
REQ-020 SHALL never assert wr and rd in the same cycle, and SHALL assert each exactly once per transaction.
REQ-021 SHALL go to ERR if WR or RD lasts TMO cycles without ack, drop the request, and pulse err for exactly one cycle.
REQ-022 SHALL pulse done for exactly one cycle in DONE.
REQ-023 SHALL ignore start rises while busy, with no queuing.
REQ-024 SHALL, on clr sampled high in any state, go to IDLE at the next edge and drop wr/rd; clr takes priority over an ack in the same cycle, and SHALL pulse neither done nor err.
REQ-025 SHALL count an ack only while its request is high; stray acks are ignored.
REQ-026 SHALL use 4-bit delay counters and an 8-bit timeout counter, reloaded on each state entry and never wrapping.

Reset
REQ-027 SHALL, with rst low, asynchronously force state IDLE, wr=0, rd=0, busy=0, done=0 and err=0, and clear all counters and the start history.
REQ-028 SHALL abort any in-flight transaction immediately on reset assertion, and SHALL NOT treat start held high through reset release as a rise.

Configuration
REQ-029 SHALL, with SEQ_HIT_CNT_EN defined, add outputs hit_wr[7:0] and hit_rd[7:0], which increment on each wr or rd handshake, saturate at 255, and clear on reset only.
REQ-030 SHALL, without SEQ_HIT_CNT_EN, have neither those ports nor their logic.

Structure
REQ-031 SHALL place the state enum typedef, counter widths and parameter limits in package wr_rd_seq_pkg.
REQ-032 SHALL use one sub-module, seq_dly_cnt: a loadable down-counter with an expire flag, instantiated for both DLY and GAP.

Verification
REQ-033 SHALL cover: with defaults and both acks tied 1, start rising at edge 2 -> wr high only at edge 4, rd high only at edge 6, done at edge 7.
REQ-034 SHALL cover: wr_ack withheld for 16 cycles -> wr drops, err pulses once, rd never asserts, busy falls on the next cycle.
REQ-035 SHALL cover: rst low at the edge after wr asserts -> all outputs 0 immediately; start still high after release -> no new transaction.
REQ-036 SHALL cover: a second start rise during GAP -> ignored, with exactly one wr and one rd.
REQ-037 SHALL cover: clr and rd_ack high together in RD -> IDLE with no done.
REQ-038 SHALL cover: SEQ_HIT_CNT_EN with 3 back-to-back transactions -> hit_wr=3 and hit_rd=3; the bench also asserts that, from the start rise, ##START_DLY rst stays deasserted throughout wr[->1] and rd[->1].
